// File: rtl/tnoc_pkg.sv
// Shared NoC types and helpers: flit field layout, flit type encoding and
// serializer FSM states.
package tnoc_pkg;

  // Number of flit-sized slices needed to carry a header of the given width.
  function automatic int get_header_flit_count(input int header_width, input int flit_data_width);
    return (header_width + flit_data_width - 1) / flit_data_width;
  endfunction

  typedef enum logic {
    TNOC_FLIT_HEADER  = 1'b0,
    TNOC_FLIT_PAYLOAD = 1'b1
  } tnoc_flit_type;

  localparam int TNOC_FLIT_TYPE_BIT = 0;
  localparam int TNOC_FLIT_HEAD_BIT = 1;
  localparam int TNOC_FLIT_TAIL_BIT = 2;
  localparam int TNOC_FLIT_DATA_LSB = 3;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_HEADER  = 2'd1,
    ST_PAYLOAD = 2'd2
  } tnoc_ser_state_e;

endpackage

// File: rtl/tnoc_round_robin_arbiter.sv
// Combinational round-robin arbiter: grants the first requester at or after
// i_pointer, searching cyclically, as a one-hot vector plus encoded index.
module tnoc_round_robin_arbiter #(
  parameter int REQUESTS = 2,
  localparam int IDX_W   = (REQUESTS > 1) ? $clog2(REQUESTS) : 1
) (
  input  logic [REQUESTS-1:0] i_request,
  input  logic [IDX_W-1:0]    i_pointer,
  input  logic                i_enable,
  output logic [REQUESTS-1:0] o_grant,
  output logic [IDX_W-1:0]    o_grant_index
);

  logic [IDX_W:0]   w_sum [REQUESTS];
  logic [IDX_W-1:0] w_idx [REQUESTS];

  // w_idx[k] is the channel visited k steps after the pointer.
  for (genvar gi = 0; gi < REQUESTS; gi++) begin : g_idx
    assign w_sum[gi] = {1'b0, i_pointer} + (IDX_W+1)'(gi);
    assign w_idx[gi] = (w_sum[gi] >= (IDX_W+1)'(REQUESTS))
                     ? IDX_W'(w_sum[gi] - (IDX_W+1)'(REQUESTS))
                     : IDX_W'(w_sum[gi]);
  end

  // Scan from the farthest offset down so the nearest requester wins.
  always_comb begin
    o_grant       = '0;
    o_grant_index = '0;
    if (i_enable) begin
      for (int i = REQUESTS - 1; i >= 0; i--) begin
        if (i_request[w_idx[i]]) begin
          o_grant             = '0;
          o_grant[w_idx[i]]   = 1'b1;
          o_grant_index       = w_idx[i];
        end
      end
    end
  end

endmodule

// File: rtl/tnoc_flit_serializer.sv
// Multi-channel packet-to-flit serializer: packet-granular round-robin over
// the input channels, header split into flit-sized slices, payload passed through.
module tnoc_flit_serializer
  import tnoc_pkg::*;
#(
  parameter int  CHANNELS        = 2,
  parameter int  HEADER_WIDTH    = 70,
  parameter int  PAYLOAD_WIDTH   = 36,
  parameter int  FLIT_DATA_WIDTH = 32,
  localparam int HEADER_FLITS    = get_header_flit_count(HEADER_WIDTH, FLIT_DATA_WIDTH),
  localparam int FLIT_WIDTH      = FLIT_DATA_WIDTH + 3,
  localparam int CH_W            = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                              i_clk,
  input  logic                              i_rst,
  input  logic [CHANNELS-1:0]               i_header_valid,
  output logic [CHANNELS-1:0]               o_header_ready,
  input  logic [CHANNELS*HEADER_WIDTH-1:0]  i_header,
  input  logic [CHANNELS-1:0]               i_header_has_payload,
  input  logic [CHANNELS-1:0]               i_payload_valid,
  output logic [CHANNELS-1:0]               o_payload_ready,
  input  logic [CHANNELS*PAYLOAD_WIDTH-1:0] i_payload,
  input  logic [CHANNELS-1:0]               i_payload_last,
  output logic                              o_flit_valid,
  input  logic                              i_flit_ready,
  output logic [FLIT_WIDTH-1:0]             o_flit,
  output logic [CH_W-1:0]                   o_flit_channel
);

  localparam int FI_W         = (HEADER_FLITS > 1) ? $clog2(HEADER_FLITS) : 1;
  localparam int HEADER_PAD_W = HEADER_FLITS * FLIT_DATA_WIDTH;

  tnoc_ser_state_e              r_state, w_state_next;
  logic [CH_W-1:0]              r_grant, w_grant_next;
  logic [CH_W-1:0]              r_rr_ptr, w_rr_ptr_next;
  logic [HEADER_WIDTH-1:0]      r_header, w_header_next;
  logic                         r_has_payload, w_has_payload_next;
  logic [FI_W-1:0]              r_flit_idx, w_flit_idx_next;

  logic [HEADER_WIDTH-1:0]      w_header_in    [CHANNELS];
  logic [FLIT_DATA_WIDTH-1:0]   w_payload_ext  [CHANNELS];
  logic [HEADER_PAD_W-1:0]      w_header_pad;
  logic [FLIT_DATA_WIDTH-1:0]   w_header_words [HEADER_FLITS];

  logic                         w_arb_enable;
  logic [CHANNELS-1:0]          w_arb_grant;
  logic [CH_W-1:0]              w_arb_index;

  logic                         w_flit_valid;
  logic                         w_head;
  logic                         w_tail;
  logic                         w_last_hdr;
  tnoc_flit_type                w_type;
  logic [FLIT_DATA_WIDTH-1:0]   w_data;

  for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_ch
    assign w_header_in[gi] = i_header[gi*HEADER_WIDTH +: HEADER_WIDTH];
    if (PAYLOAD_WIDTH >= FLIT_DATA_WIDTH) begin : g_trunc
      assign w_payload_ext[gi] = i_payload[gi*PAYLOAD_WIDTH +: FLIT_DATA_WIDTH];
    end else begin : g_zext
      assign w_payload_ext[gi] = {{(FLIT_DATA_WIDTH-PAYLOAD_WIDTH){1'b0}},
                                  i_payload[gi*PAYLOAD_WIDTH +: PAYLOAD_WIDTH]};
    end
  end

  // Zero-pad the header so the last slice is full width.
  if (HEADER_PAD_W > HEADER_WIDTH) begin : g_pad
    assign w_header_pad = {{(HEADER_PAD_W-HEADER_WIDTH){1'b0}}, r_header};
  end else begin : g_nopad
    assign w_header_pad = r_header;
  end

  for (genvar gi = 0; gi < HEADER_FLITS; gi++) begin : g_words
    assign w_header_words[gi] = w_header_pad[gi*FLIT_DATA_WIDTH +: FLIT_DATA_WIDTH];
  end

  assign w_arb_enable = (r_state == ST_IDLE) && !i_rst;

  tnoc_round_robin_arbiter #(
    .REQUESTS (CHANNELS)
  ) u_arbiter (
    .i_request     (i_header_valid),
    .i_pointer     (r_rr_ptr),
    .i_enable      (w_arb_enable),
    .o_grant       (w_arb_grant),
    .o_grant_index (w_arb_index)
  );

  assign w_last_hdr = (r_flit_idx == FI_W'(HEADER_FLITS - 1));

  always_comb begin
    w_state_next       = r_state;
    w_grant_next       = r_grant;
    w_rr_ptr_next      = r_rr_ptr;
    w_header_next      = r_header;
    w_has_payload_next = r_has_payload;
    w_flit_idx_next    = r_flit_idx;
    o_header_ready     = '0;
    o_payload_ready    = '0;
    w_flit_valid       = 1'b0;
    w_type             = TNOC_FLIT_HEADER;
    w_head             = 1'b0;
    w_tail             = 1'b0;
    w_data             = '0;

    case (r_state)
      ST_IDLE: begin
        if (|w_arb_grant) begin
          o_header_ready     = w_arb_grant;
          w_grant_next       = w_arb_index;
          w_header_next      = w_header_in[w_arb_index];
          w_has_payload_next = i_header_has_payload[w_arb_index];
          w_flit_idx_next    = '0;
          w_rr_ptr_next      = (w_arb_index == CH_W'(CHANNELS - 1)) ? '0 : w_arb_index + CH_W'(1);
          w_state_next       = ST_HEADER;
        end
      end

      ST_HEADER: begin
        w_flit_valid = 1'b1;
        w_type       = TNOC_FLIT_HEADER;
        w_data       = w_header_words[r_flit_idx];
        w_head       = (r_flit_idx == '0);
        w_tail       = w_last_hdr && !r_has_payload;
        if (i_flit_ready) begin
          if (w_last_hdr) begin
            w_state_next = r_has_payload ? ST_PAYLOAD : ST_IDLE;
          end else begin
            w_flit_idx_next = r_flit_idx + FI_W'(1);
          end
        end
      end

      ST_PAYLOAD: begin
        // Pure pass-through; the upstream beat holds itself under backpressure.
        w_flit_valid             = i_payload_valid[r_grant];
        o_payload_ready[r_grant] = i_flit_ready;
        w_type                   = TNOC_FLIT_PAYLOAD;
        w_tail                   = i_payload_last[r_grant];
        w_data                   = w_payload_ext[r_grant];
        if (i_payload_valid[r_grant] && i_flit_ready && i_payload_last[r_grant]) begin
          w_state_next = ST_IDLE;
        end
      end

      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state       <= ST_IDLE;
      r_grant       <= '0;
      r_rr_ptr      <= '0;
      r_header      <= '0;
      r_has_payload <= 1'b0;
      r_flit_idx    <= '0;
    end else begin
      r_state       <= w_state_next;
      r_grant       <= w_grant_next;
      r_rr_ptr      <= w_rr_ptr_next;
      r_header      <= w_header_next;
      r_has_payload <= w_has_payload_next;
      r_flit_idx    <= w_flit_idx_next;
    end
  end

  assign o_flit_valid = w_flit_valid;

  // Flit and channel read as zero whenever no flit is offered.
  always_comb begin
    o_flit         = '0;
    o_flit_channel = '0;
    if (w_flit_valid) begin
      o_flit[TNOC_FLIT_TYPE_BIT]                     = w_type;
      o_flit[TNOC_FLIT_HEAD_BIT]                     = w_head;
      o_flit[TNOC_FLIT_TAIL_BIT]                     = w_tail;
      o_flit[TNOC_FLIT_DATA_LSB +: FLIT_DATA_WIDTH]  = w_data;
      o_flit_channel                                 = r_grant;
    end
  end

endmodule

// File: tb/tb_tnoc_flit_serializer.sv
// Bench for tnoc_flit_serializer: packet-level reference model (per-channel
// expected flit queues plus a round-robin pointer) checked every cycle.
module tb_tnoc_flit_serializer;

  localparam int N   = 4;
  localparam int HW  = 70;
  localparam int PW  = 24;
  localparam int FDW = 32;
  localparam int HF  = (HW + FDW - 1) / FDW;
  localparam int FW  = FDW + 3;
  localparam int CHW = 2;

  typedef struct packed { logic [HW-1:0] hdr; logic has_pl; } hdr_t;
  typedef struct packed { logic [PW-1:0] data; logic last; } beat_t;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [N-1:0]      i_header_valid = '0;
  logic [N-1:0]      o_header_ready;
  logic [N*HW-1:0]   i_header = '0;
  logic [N-1:0]      i_header_has_payload = '0;
  logic [N-1:0]      i_payload_valid = '0;
  logic [N-1:0]      o_payload_ready;
  logic [N*PW-1:0]   i_payload = '0;
  logic [N-1:0]      i_payload_last = '0;
  logic              o_flit_valid;
  logic              i_flit_ready = 1'b0;
  logic [FW-1:0]     o_flit;
  logic [CHW-1:0]    o_flit_channel;

  tnoc_flit_serializer #(
    .CHANNELS        (N),
    .HEADER_WIDTH    (HW),
    .PAYLOAD_WIDTH   (PW),
    .FLIT_DATA_WIDTH (FDW)
  ) dut (
    .i_clk                (clk),
    .i_rst                (rst),
    .i_header_valid       (i_header_valid),
    .o_header_ready       (o_header_ready),
    .i_header             (i_header),
    .i_header_has_payload (i_header_has_payload),
    .i_payload_valid      (i_payload_valid),
    .o_payload_ready      (o_payload_ready),
    .i_payload            (i_payload),
    .i_payload_last       (i_payload_last),
    .o_flit_valid         (o_flit_valid),
    .i_flit_ready         (i_flit_ready),
    .o_flit               (o_flit),
    .o_flit_channel       (o_flit_channel)
  );

  always #5 clk = ~clk;

  hdr_t          hdr_q [N][$];
  beat_t         pay_q [N][$];
  logic [FW-1:0] exp_q [N][$];
  int            grant_log[$];
  int            stall_pts[$];
  logic          offering [N];

  int n_checks = 0;
  int n_errors = 0;
  int rr = 0, cur = 0, emitted = 0, cycle = 0, pkt_start = 0, last_pkt_cycles = 0;
  int stall_cnt = 0;
  bit in_flight = 1'b0, pl_gaps = 1'b0, rand_ready = 1'b0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cycle);
    end
  endtask

  function automatic bit busy();
    bit b = in_flight;
    for (int c = 0; c < N; c++) b |= (hdr_q[c].size() > 0) || (pay_q[c].size() > 0);
    return b;
  endfunction

  // Builds the packet's expected flit sequence straight from the flit format.
  task automatic add_packet(input int c, input logic [HW-1:0] hdr, input int beats);
    logic [HF*FDW-1:0] wide;
    logic [FDW-1:0]    word;
    hdr_t              h;
    beat_t             bt;
    h.hdr = hdr; h.has_pl = (beats > 0);
    hdr_q[c].push_back(h);
    wide = '0;
    wide[HW-1:0] = hdr;
    for (int k = 0; k < HF; k++) begin
      word = FDW'(wide >> (k * FDW));
      exp_q[c].push_back({word, (k == HF-1) && (beats == 0), k == 0, 1'b0});
    end
    for (int b = 0; b < beats; b++) begin
      bt.data = PW'($urandom);
      bt.last = (b == beats - 1);
      pay_q[c].push_back(bt);
      exp_q[c].push_back({FDW'(bt.data), bt.last, 1'b0, 1'b1});
    end
  endtask

  task automatic step();
    logic [N-1:0]  hv, exp_hr, exp_pr;
    logic          exp_fv;
    logic [FW-1:0] f;
    int            pick;
    @(negedge clk);
    for (int c = 0; c < N; c++) begin
      hv[c] = hdr_q[c].size() > 0;
      i_header_valid[c]       = hv[c];
      i_header[c*HW +: HW]    = hv[c] ? hdr_q[c][0].hdr : '0;
      i_header_has_payload[c] = hv[c] ? hdr_q[c][0].has_pl : 1'b0;
      if (pay_q[c].size() > 0 && !offering[c] && (!pl_gaps || $urandom_range(0, 2) != 0))
        offering[c] = 1'b1;
      i_payload_valid[c]      = offering[c];
      i_payload[c*PW +: PW]   = offering[c] ? pay_q[c][0].data : '0;
      i_payload_last[c]       = offering[c] ? pay_q[c][0].last : 1'b0;
    end
    if (stall_cnt == 0 && in_flight && stall_pts.size() > 0 && emitted == stall_pts[0]) begin
      stall_cnt = 5;
      void'(stall_pts.pop_front());
    end
    if (stall_cnt > 0) begin
      i_flit_ready = 1'b0;
      stall_cnt--;
    end else begin
      i_flit_ready = rand_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
    end
    #1;
    cycle++;

    exp_hr = '0;
    pick   = -1;
    if (!in_flight)
      for (int o = 0; o < N; o++)
        if (pick < 0 && hv[(rr + o) % N]) pick = (rr + o) % N;
    if (pick >= 0) exp_hr[pick] = 1'b1;
    check("hdr_rdy", o_header_ready, exp_hr);

    exp_fv = in_flight && (emitted < HF || i_payload_valid[cur]);
    check("flit_vld", o_flit_valid, exp_fv);
    exp_pr = '0;
    if (in_flight && emitted >= HF) exp_pr[cur] = i_flit_ready;
    check("pl_rdy", o_payload_ready, exp_pr);

    if (exp_fv) begin
      check("flit_ch", o_flit_channel, cur);
      f = (exp_q[cur].size() > 0) ? exp_q[cur][0] : '0;
      check("flit", o_flit, f);
      if (i_flit_ready) begin
        if (exp_q[cur].size() > 0) void'(exp_q[cur].pop_front());
        if (emitted >= HF) begin
          void'(pay_q[cur].pop_front());
          offering[cur] = 1'b0;
        end
        emitted++;
        if (f[2]) begin
          in_flight = 1'b0;
          last_pkt_cycles = cycle - pkt_start + 1;
        end
      end
    end
    if (pick >= 0) begin
      void'(hdr_q[pick].pop_front());
      in_flight = 1'b1;
      cur       = pick;
      emitted   = 0;
      rr        = (pick + 1) % N;
      pkt_start = cycle;
      grant_log.push_back(pick);
    end
  endtask

  task automatic run_idle(input int max_cycles);
    int n = 0;
    while (busy() && n < max_cycles) begin
      step();
      n++;
    end
    check("drain", busy(), 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    for (int c = 0; c < N; c++) begin
      hdr_q[c].delete(); pay_q[c].delete(); exp_q[c].delete();
      offering[c] = 1'b0;
    end
    grant_log.delete();
    stall_pts.delete();
    in_flight = 1'b0; rr = 0; emitted = 0; stall_cnt = 0;
    i_header_valid = '0; i_header = '0; i_header_has_payload = '0;
    i_payload_valid = '0; i_payload = '0; i_payload_last = '0; i_flit_ready = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst_flit_vld", o_flit_valid, 0);
    check("rst_hdr_rdy", o_header_ready, 0);
    check("rst_pl_rdy", o_payload_ready, 0);
    check("rst_flit", o_flit, 0);
    check("rst_flit_ch", o_flit_channel, 0);
  endtask

  initial begin
    int n;
    logic [HW-1:0] h;
    for (int c = 0; c < N; c++) offering[c] = 1'b0;

    // Single header-only packet with the reference header.
    do_reset();
    h = 70'h3_0123_4567_89AB_CDEF;
    add_packet(0, h, 0);
    run_idle(40);
    check("pkt1_cycles", last_pkt_cycles, 1 + HF);

    // ch1 packet with four payload beats.
    do_reset();
    add_packet(1, HW'({$urandom, $urandom, $urandom}), 4);
    run_idle(40);
    check("pkt2_cycles", last_pkt_cycles, 1 + HF + 4);

    // All channels requesting at once; ch0 has a second packet.
    do_reset();
    for (int c = 0; c < N; c++) add_packet(c, HW'({$urandom, $urandom, $urandom}), c % 2);
    add_packet(0, HW'({$urandom, $urandom, $urandom}), 0);
    run_idle(100);
    for (int k = 0; k < 5; k++)
      check("grant_order", (k < grant_log.size()) ? grant_log[k] : -1, k % N);

    // Backpressure during header flit 1 and payload beat 2.
    do_reset();
    stall_pts.push_back(1);
    stall_pts.push_back(HF + 1);
    add_packet(0, HW'({$urandom, $urandom, $urandom}), 3);
    run_idle(60);
    check("stall_pkt_cycles", last_pkt_cycles, 1 + HF + 3 + 10);

    // ch1 payload offered early while ch0 owns the output.
    do_reset();
    add_packet(0, HW'({$urandom, $urandom, $urandom}), 2);
    add_packet(1, HW'({$urandom, $urandom, $urandom}), 2);
    run_idle(60);

    // Reset mid-payload, then arbitration restarts from pointer 0.
    do_reset();
    add_packet(0, HW'({$urandom, $urandom, $urandom}), 0);
    run_idle(40);
    add_packet(1, HW'({$urandom, $urandom, $urandom}), 4);
    n = 0;
    while (!(in_flight && emitted == HF + 1) && n < 50) begin
      step();
      n++;
    end
    check("rst_point", emitted, HF + 1);
    do_reset();
    add_packet(3, HW'({$urandom, $urandom, $urandom}), 1);
    add_packet(0, HW'({$urandom, $urandom, $urandom}), 1);
    run_idle(60);
    check("post_rst_grant", (grant_log.size() > 0) ? grant_log[0] : -1, 0);

    // Randomized traffic with payload gaps and downstream backpressure.
    do_reset();
    pl_gaps    = 1'b1;
    rand_ready = 1'b1;
    for (int p = 0; p < 60; p++)
      add_packet($urandom_range(0, N - 1), HW'({$urandom, $urandom, $urandom}), $urandom_range(0, 5));
    run_idle(5000);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
